signed_alu_seq: RTL and testbench
=================================

Name: signed_alu_seq

Overview:
- Parametrised signed arithmetic unit: add, subtract, multiply and an optional multiply-accumulate on two's-complement operands of width W.
- Single-cycle add/sub; multiply is an iterative shift-add engine of W cycles.
- Sits between operand producers and result consumers.
- valid/ready handshake on both sides; one operation in flight at a time.
- Output is a 2W-bit result register held until consumed.

Parameters:
W, 17, operand width in bits (signed two's complement), legal range 4..32
RW, 2*W, result width; derived, not to be overridden

Ports:
clk  input  1  clock, all state rising-edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
in_valid  input  1  operand/op request valid
in_ready  output  1  unit can accept request this cycle
op  input  2  00 ADD, 01 SUB, 10 MUL, 11 MAC (see Optional Feature)
a  input  W  signed operand A
b  input  W  signed operand B
acc_clr  input  1  synchronous accumulator clear; ignored without feature
out_valid  output  1  result register holds unconsumed result
out_ready  input  1  consumer accepts result
result  output  RW  signed result, sign-extended to RW
op_err  output  1  qualifies result; 1 = illegal op, result forced 0
busy  output  1  multiply engine active

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, out_valid=0, result=0, op_err=0, busy=0, accumulator=0. in_ready=0 while rst=0.
- Reset mid-multiply aborts the operation; nothing is emitted after release.
- in_ready = (state==IDLE) && (!out_valid || out_ready); combinational.
- Accept = in_valid && in_ready at a clk edge; a, b and op are captured at that edge.
- Output handshake: result and op_err are stable while out_valid=1 && out_ready=0. Consume = out_valid && out_ready.
- Consume and accept may occur at the same edge: the new ADD/SUB result loads, so out_valid stays 1 with no bubble.
- States: IDLE, MUL (engine iterating), LOAD (final sign fix, load result register).
- ADD/SUB:
  - Computed at W+1 bits from sign-extended operands, then sign-extended to RW; never overflows.
  - Result register loads at the accept edge; out_valid=1 the cycle after accept (latency 1). State stays IDLE.
- MUL/MAC:
  - At accept: capture |a|, |b| as W-bit unsigned, record sign = a[W-1]^b[W-1], clear product, counter=0; IDLE->MUL; busy=1.
  - -2^(W-1) magnitude is 2^(W-1), which fits W unsigned bits.
  - In MUL, one multiplier bit per cycle (shift-add). After W iterations (counter==W-1), MUL->LOAD.
  - LOAD negates the product if sign=1 and loads the result register (MAC also adds the accumulator, wrapping mod 2^RW). LOAD->IDLE; busy=0.
  - out_valid rises W+1 cycles after the accept edge. Full-range products fit in RW bits exactly: no overflow.
- Zero operand takes the full W+1 latency; no early termination.
- in_ready stays 0 during MUL/LOAD regardless of out_ready.
- Illegal op (MAC without feature): treated as 1-cycle op; result=0, op_err=1. op_err=0 for every legal op.

Optional Feature:
- Macro: SIGNED_ALU_MAC_EN.
- Defined:
  - op 11 = MAC: result = acc + a*b, with the same latency as MUL.
  - The RW-bit accumulator is updated to the new result in LOAD.
  - acc_clr=1 at an edge zeroes acc; if coincident with a MAC LOAD, the clear wins and acc=0, while result still shows the pre-clear sum.
  - MUL, ADD and SUB do not touch acc.
- Not defined: no accumulator storage; acc_clr ignored; op 11 returns result=0, op_err=1, latency 1.

Test Plan:
- ADD W=17: a=17'h0FFFF, b=17'h00001 -> result=34'h0_0001_0000 one cycle after accept, op_err=0.
- SUB: a=17'h10000 (-65536), b=1 -> result=34'h3_FFFE_FFFF (-65537), latency 1; back-to-back SUBs with out_ready=1 give one result per cycle.
- MUL: a=-3, b=5 -> result=-15 (34'h3_FFFF_FFF1) exactly 18 cycles after accept, busy high 17 cycles; a=b=17'h10000 -> 34'h1_0000_0000.
- Backpressure: MUL done, out_ready=0 for 5 cycles -> result held, in_ready=0; out_ready=1 -> consume, in_ready=1 the same cycle.
- Reset mid-MUL: rst=0 at cycle 8 of a multiply -> out_valid=0, result=0, busy=0 immediately; no result after release; next ADD 2+2=4 is correct.
- MAC (SIGNED_ALU_MAC_EN): MAC 3*4 then MAC -2*5 -> results 12 then 2; acc_clr then MAC 1*1 -> 1. Without the macro, op=11 -> result=0, op_err=1 after 1 cycle.

Source files
------------

// File: rtl/signed_alu_seq_if.sv
// Handshake bundle for signed_alu_seq: operand request side and result side.
// The DUT connects through the slave modport; producers/consumers use master.
interface signed_alu_seq_if #(
    parameter int W = 17
) ();
    localparam int RW = 2 * W;

    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;
    logic          op_err;
    logic          busy;

    modport slave (
        input  in_valid, op, a, b, acc_clr, out_ready,
        output in_ready, out_valid, result, op_err, busy
    );

    modport master (
        output in_valid, op, a, b, acc_clr, out_ready,
        input  in_ready, out_valid, result, op_err, busy
    );
endinterface

// File: rtl/signed_alu_seq.sv
// signed_alu_seq: signed add/sub (1 cycle) and iterative shift-add multiply
// (W+1 cycles) with a held 2W-bit result register and valid/ready on both sides.
// Optional multiply-accumulate (op 11) enabled by defining SIGNED_ALU_MAC_EN;
// without it op 11 is reported as illegal (result 0, op_err 1).
module signed_alu_seq #(
    parameter  int W  = 17,
    localparam int RW = 2 * W
) (
    input logic            clk,
    input logic            rst,
    signed_alu_seq_if.slave bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_LOAD} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] mcand_q, mcand_d;     // |a|, shifted left once per iteration
    logic [W-1:0]  mplier_q, mplier_d;   // |b|, shifted right once per iteration
    logic [RW-1:0] prod_q, prod_d;       // unsigned magnitude product
    logic          sign_q, sign_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [RW-1:0] result_q, result_d;
    logic          op_err_q, op_err_d;

    logic          in_ready;
    logic          accept;
    logic          consume;
    logic [W-1:0]  mag_a, mag_b;
    logic [W:0]    sum_w1, dif_w1;
    logic [RW-1:0] prod_signed;
    logic [RW-1:0] final_res;

`ifdef SIGNED_ALU_MAC_EN
    logic [RW-1:0] acc_q, acc_d;
    logic          is_mac_q, is_mac_d;
`else
    logic          unused_acc_clr;
    assign unused_acc_clr = bus.acc_clr;
`endif

    assign in_ready     = rst && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && in_ready;
    assign consume      = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.op_err    = op_err_q;
    assign bus.busy      = (state_q == S_MUL);

    // Operand magnitudes, W+1-bit add/sub and the sign-fixed final product
    always_comb begin
        mag_a       = bus.a[W-1] ? (~bus.a + W'(1)) : bus.a;
        mag_b       = bus.b[W-1] ? (~bus.b + W'(1)) : bus.b;
        sum_w1      = {bus.a[W-1], bus.a} + {bus.b[W-1], bus.b};
        dif_w1      = {bus.a[W-1], bus.a} - {bus.b[W-1], bus.b};
        prod_signed = sign_q ? (~prod_q + RW'(1)) : prod_q;
`ifdef SIGNED_ALU_MAC_EN
        final_res   = is_mac_q ? (prod_signed + acc_q) : prod_signed;
`else
        final_res   = prod_signed;
`endif
    end

    // Next-state / datapath: IDLE accepts, MUL iterates W times, LOAD emits
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        sign_d      = sign_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        op_err_d    = op_err_q;
`ifdef SIGNED_ALU_MAC_EN
        acc_d       = acc_q;
        is_mac_d    = is_mac_q;
`endif
        if (consume) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.op)
                        2'b00: begin
                            result_d    = {{(RW-W-1){sum_w1[W]}}, sum_w1};
                            op_err_d    = 1'b0;
                            out_valid_d = 1'b1;
                        end
                        2'b01: begin
                            result_d    = {{(RW-W-1){dif_w1[W]}}, dif_w1};
                            op_err_d    = 1'b0;
                            out_valid_d = 1'b1;
                        end
`ifdef SIGNED_ALU_MAC_EN
                        2'b10, 2'b11: begin
                            is_mac_d = bus.op[0];
`else
                        2'b10: begin
`endif
                            mcand_d  = {{W{1'b0}}, mag_a};
                            mplier_d = mag_b;
                            prod_d   = '0;
                            sign_d   = bus.a[W-1] ^ bus.b[W-1];
                            cnt_d    = '0;
                            state_d  = S_MUL;
                        end
                        default: begin
                            result_d    = '0;
                            op_err_d    = 1'b1;
                            out_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (mplier_q[0]) prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) state_d = S_LOAD;
            end
            S_LOAD: begin
                result_d    = final_res;
                op_err_d    = 1'b0;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
`ifdef SIGNED_ALU_MAC_EN
                if (is_mac_q) acc_d = final_res;
`endif
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SIGNED_ALU_MAC_EN
        // A clear coincident with a MAC load wins over the accumulator update
        if (bus.acc_clr) acc_d = '0;
`endif
    end

    // State and datapath registers; reset aborts any multiply in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            sign_q      <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            op_err_q    <= 1'b0;
`ifdef SIGNED_ALU_MAC_EN
            acc_q       <= '0;
            is_mac_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            sign_q      <= sign_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            op_err_q    <= op_err_d;
`ifdef SIGNED_ALU_MAC_EN
            acc_q       <= acc_d;
            is_mac_q    <= is_mac_d;
`endif
        end
    end
endmodule

// File: tb/tb_signed_alu_seq.sv
// Directed bench for signed_alu_seq (W=17): reset, add/sub, multiply latency,
// backpressure, reset mid-multiply, and op 11 (MAC or illegal per build).
module tb_signed_alu_seq;
    localparam int W = 17;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc;
    int   bcnt;
    logic seen_ov;

    signed_alu_seq_if #(.W(W)) bus ();

    signed_alu_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until out_valid, and cycles with busy seen on the way
    task automatic wait_ov(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (!bus.out_valid && n < 100) begin
            if (bus.busy) nb++;
            step();
            n++;
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.a         = '0;
        bus.b         = '0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result",    64'(bus.result),    64'd0);
        check("rst_op_err",    64'(bus.op_err),    64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        step();
        step();
        rst = 1'b1;

        // ADD 0x0FFFF + 1
        bus.in_valid = 1'b1;
        bus.op = 2'b00; bus.a = 17'h0FFFF; bus.b = 17'h00001;
        #1;
        check("add_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("add_valid",  64'(bus.out_valid), 64'd1);
        check("add_result", 64'(bus.result),    64'h0_0001_0000);
        check("add_err",    64'(bus.op_err),    64'd0);

        // Back-to-back SUBs, one result per cycle
        bus.op = 2'b01; bus.a = 17'h10000; bus.b = 17'h00001;
        step();
        check("sub1_valid",  64'(bus.out_valid), 64'd1);
        check("sub1_result", 64'(bus.result),    64'h3_FFFE_FFFF);
        bus.a = 17'd5; bus.b = 17'd7;
        step();
        check("sub2_valid",  64'(bus.out_valid), 64'd1);
        check("sub2_result", 64'(bus.result),    64'h3_FFFF_FFFE);
        bus.in_valid = 1'b0;
        step();
        check("sub_drain", 64'(bus.out_valid), 64'd0);

        // MUL -3 * 5
        bus.in_valid = 1'b1;
        bus.op = 2'b10; bus.a = 17'h1FFFD; bus.b = 17'd5;
        step();
        bus.in_valid = 1'b0;
        check("mul_in_ready_busy", 64'(bus.in_ready), 64'd0);
        wait_ov(cyc, bcnt);
        check("mul1_latency", 64'(cyc),        64'd18);
        check("mul1_busy",    64'(bcnt),       64'd17);
        check("mul1_result",  64'(bus.result), 64'h3_FFFF_FFF1);
        check("mul1_err",     64'(bus.op_err), 64'd0);
        step();
        check("mul1_consumed", 64'(bus.out_valid), 64'd0);

        // MUL -65536 * -65536 with backpressure
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.op = 2'b10; bus.a = 17'h10000; bus.b = 17'h10000;
        step();
        bus.in_valid = 1'b0;
        wait_ov(cyc, bcnt);
        check("mul2_latency", 64'(cyc),        64'd18);
        check("mul2_result",  64'(bus.result), 64'h1_0000_0000);
        repeat (5) step();
        check("bp_valid",    64'(bus.out_valid), 64'd1);
        check("bp_result",   64'(bus.result),    64'h1_0000_0000);
        check("bp_in_ready", 64'(bus.in_ready),  64'd0);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("bp_consumed", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of a multiply
        bus.in_valid = 1'b1;
        bus.op = 2'b10; bus.a = 17'd7; bus.b = 17'd9;
        step();
        bus.in_valid = 1'b0;
        repeat (7) step();
        rst = 1'b0;
        #1;
        check("rstmul_valid",  64'(bus.out_valid), 64'd0);
        check("rstmul_result", 64'(bus.result),    64'd0);
        check("rstmul_busy",   64'(bus.busy),      64'd0);
        step();
        rst = 1'b1;
        seen_ov = 1'b0;
        repeat (25) begin
            step();
            if (bus.out_valid) seen_ov = 1'b1;
        end
        check("rstmul_no_emit", 64'(seen_ov), 64'd0);
        bus.in_valid = 1'b1;
        bus.op = 2'b00; bus.a = 17'd2; bus.b = 17'd2;
        step();
        bus.in_valid = 1'b0;
        check("post_rst_add", 64'(bus.result), 64'd4);
        step();

`ifdef SIGNED_ALU_MAC_EN
        // MAC 3*4, MAC -2*5, clear, MAC 1*1
        bus.in_valid = 1'b1;
        bus.op = 2'b11; bus.a = 17'd3; bus.b = 17'd4;
        step();
        bus.in_valid = 1'b0;
        wait_ov(cyc, bcnt);
        check("mac1_latency", 64'(cyc),        64'd18);
        check("mac1_result",  64'(bus.result), 64'd12);
        step();
        bus.in_valid = 1'b1;
        bus.op = 2'b11; bus.a = 17'h1FFFE; bus.b = 17'd5;
        step();
        bus.in_valid = 1'b0;
        wait_ov(cyc, bcnt);
        check("mac2_result", 64'(bus.result), 64'd2);
        step();
        bus.acc_clr = 1'b1;
        step();
        bus.acc_clr = 1'b0;
        bus.in_valid = 1'b1;
        bus.op = 2'b11; bus.a = 17'd1; bus.b = 17'd1;
        step();
        bus.in_valid = 1'b0;
        wait_ov(cyc, bcnt);
        check("mac3_result", 64'(bus.result), 64'd1);
        check("mac3_err",    64'(bus.op_err), 64'd0);
        step();
`else
        // op 11 is illegal without the accumulator
        bus.in_valid = 1'b1;
        bus.op = 2'b11; bus.a = 17'd5; bus.b = 17'd6;
        step();
        bus.in_valid = 1'b0;
        check("illegal_valid",  64'(bus.out_valid), 64'd1);
        check("illegal_result", 64'(bus.result),    64'd0);
        check("illegal_err",    64'(bus.op_err),    64'd1);
        step();
        bus.in_valid = 1'b1;
        bus.op = 2'b00; bus.a = 17'd1; bus.b = 17'd1;
        step();
        bus.in_valid = 1'b0;
        check("legal_after_err_result", 64'(bus.result), 64'd2);
        check("legal_after_err_err",    64'(bus.op_err), 64'd0);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
